// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: shifts a TAPS-deep delay line per input sample and
// steps one shared external multiplier through every tap, accumulating with saturation.
module fir_mac_sequencer #(
  parameter int N     = 23,
  parameter int DECIM = 14,
  parameter int TAPS  = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  x_in,
  input  logic          x_valid,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [N-1:0]  coef_data,
  output logic [N-1:0]  mult_a,
  output logic [N-1:0]  mult_b,
  input  logic [N-1:0]  mult_p,
  output logic [N-1:0]  y_out,
  output logic          y_valid,
  output logic          busy,
  output logic          overrun
);

  if ((2 ** AW) < TAPS || DECIM >= N) begin : g_param_check
    $error("fir_mac_sequencer: AW too narrow for TAPS or DECIM >= N");
  end

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  localparam logic signed [N:0]  SAT_MAX = (N+1)'((2 ** (N-1)) - 1);
  localparam logic signed [N:0]  SAT_MIN = -SAT_MAX;
  localparam logic [AW-1:0]      LAST    = AW'(TAPS - 1);

  state_t                state, state_n;
  logic [N-1:0]          delay [TAPS];
  logic [N-1:0]          coef  [TAPS];
  logic signed [N-1:0]   acc, acc_next;
  logic [AW-1:0]         idx;

  // Symmetric clamp: the most-negative code is never produced.
  function automatic logic signed [N-1:0] satadd(input logic signed [N-1:0] a,
                                                 input logic signed [N-1:0] b);
    logic signed [N:0] s;
    s = {a[N-1], a} + {b[N-1], b};
    if (s > SAT_MAX)      return SAT_MAX[N-1:0];
    else if (s < SAT_MIN) return SAT_MIN[N-1:0];
    else                  return s[N-1:0];
  endfunction

  always_comb acc_next = satadd(acc, mult_p);

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    y_valid = 1'b0;
    overrun = 1'b0;
    mult_a  = '0;
    mult_b  = '0;
    case (state)
      IDLE: begin
        if (x_valid) state_n = MAC;
      end
      MAC: begin
        busy    = 1'b1;
        overrun = x_valid;
        mult_a  = coef[idx];
        mult_b  = delay[idx];
        if (idx == LAST) state_n = OUT;
      end
      OUT: begin
        busy    = 1'b1;
        y_valid = 1'b1;
        overrun = x_valid;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      idx   <= '0;
      y_out <= '0;
      for (int unsigned i = 0; i < TAPS; i++) begin
        delay[i] <= '0;
        coef[i]  <= '0;
      end
    end else begin
      state <= state_n;
      if (coef_we && (32'(coef_addr) < 32'(TAPS)))
        coef[coef_addr] <= coef_data;
      case (state)
        IDLE: begin
          if (x_valid) begin
            delay[0] <= x_in;
            for (int unsigned k = 1; k < TAPS; k++)
              delay[k] <= delay[k-1];
            acc <= '0;
            idx <= '0;
          end
        end
        MAC: begin
          acc <= acc_next;
          idx <= idx + 1'b1;
          // y_out is loaded with the final sum on entry to OUT so it is valid alongside y_valid.
          if (idx == LAST) y_out <= acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with a saturating Q-format multiplier model
// (DECIM=14) wired to the shared multiplier ports.
module tb_fir_mac_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [22:0] x_in = '0;
  logic        x_valid = 1'b0;
  logic        coef_we = 1'b0;
  logic [2:0]  coef_addr = '0;
  logic [22:0] coef_data = '0;
  logic [22:0] mult_a, mult_b, mult_p;
  logic [22:0] y_out;
  logic        y_valid, busy, overrun;

  logic [22:0] s_x_in = '0;
  logic        s_x_valid = 1'b0;
  logic        s_coef_we = 1'b0;
  logic [2:0]  s_coef_addr = '0;
  logic [22:0] s_coef_data = '0;
  logic [22:0] s_mult_a, s_mult_b, s_mult_p;
  logic [22:0] s_y_out;
  logic        s_y_valid, s_busy, s_overrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fir_mac_sequencer #(.N(23), .DECIM(14), .TAPS(8), .AW(3)) dut (
    .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
    .y_out(y_out), .y_valid(y_valid), .busy(busy), .overrun(overrun)
  );

  // Five-tap instance leaves addresses 5..7 out of range for the ignored-write check.
  fir_mac_sequencer #(.N(23), .DECIM(14), .TAPS(5), .AW(3)) dut_small (
    .clk(clk), .reset(reset), .x_in(s_x_in), .x_valid(s_x_valid),
    .coef_we(s_coef_we), .coef_addr(s_coef_addr), .coef_data(s_coef_data),
    .mult_a(s_mult_a), .mult_b(s_mult_b), .mult_p(s_mult_p),
    .y_out(s_y_out), .y_valid(s_y_valid), .busy(s_busy), .overrun(s_overrun)
  );

  function automatic logic [22:0] qmul(input logic signed [22:0] a, input logic signed [22:0] b);
    longint p;
    p = (longint'(a) * longint'(b)) >>> 14;
    if (p > 4194303)       p = 4194303;
    else if (p < -4194303) p = -4194303;
    return p[22:0];
  endfunction

  always_comb mult_p   = qmul(mult_a, mult_b);
  always_comb s_mult_p = qmul(s_mult_a, s_mult_b);

  typedef struct {
    int cset;
    int x;
    int y;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wcoef(input int a, input int d);
    coef_we   = 1'b1;
    coef_addr = 3'(a);
    coef_data = 23'(d);
    @(posedge clk);
    #1 coef_we = 1'b0;
  endtask

  task automatic load_set(input int s);
    int d;
    for (int a = 0; a < 8; a++) begin
      if (s == 0)      d = (a == 0) ? 16384 : (a == 1) ? 8192 : (a == 2) ? -4096 : 0;
      else if (s == 1) d = 1638400;
      else             d = -1638400;
      wcoef(a, d);
    end
  endtask

  task automatic wait_y(output int y, output int cyc);
    y   = 0;
    cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (y_valid) begin
        y   = int'($signed(y_out));
        cyc = c;
        break;
      end
    end
    if (cyc < 0) begin
      total++;
      bad++;
      $display("FAIL y_valid timeout: got none expected within 20 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int x, output int y, output int cyc);
    x_in    = 23'(x);
    x_valid = 1'b1;
    @(posedge clk);
    #1 x_valid = 1'b0;
    wait_y(y, cyc);
  endtask

  initial begin
    int y, cyc, seen, got, sy;

    tbl[0] = '{0, 16384, 16384};
    tbl[1] = '{0, 0, 8192};
    tbl[2] = '{0, 0, -4096};
    for (int i = 3; i < 8; i++) tbl[i] = '{0, 0, 0};
    tbl[8]  = '{1, 16384, 1638400};
    tbl[9]  = '{1, 16384, 3276800};
    tbl[10] = '{1, 16384, 4194303};
    tbl[11] = '{1, 16384, 4194303};
    tbl[12] = '{2, 16384, -1638400};
    tbl[13] = '{2, 16384, -3276800};
    tbl[14] = '{2, 16384, -4194303};
    tbl[15] = '{2, 16384, -4194303};

    // Reset state and handshake timing
    do_reset();
    check("reset busy", int'(busy), 0);
    check("reset y_valid", int'(y_valid), 0);
    check("reset y_out", int'(y_out), 0);
    check("reset overrun", int'(overrun), 0);
    load_set(0);
    check("idle mult_a", int'(mult_a), 0);
    check("idle mult_b", int'(mult_b), 0);
    x_in    = 23'(300);
    x_valid = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      check($sformatf("busy c%0d", c), int'(busy), (c >= 1 && c <= 9) ? 1 : 0);
      check($sformatf("y_valid c%0d", c), int'(y_valid), (c == 9) ? 1 : 0);
      if (c == 1) begin
        check("mac mult_a", int'(mult_a), 16384);
        check("mac mult_b", int'(mult_b), 300);
      end
      if (c == 9) check("latency y_out", int'($signed(y_out)), 300);
      @(posedge clk);
      #1 x_valid = 1'b0;
    end

    // Impulse response and saturation vectors
    for (int i = 0; i < 16; i++) begin
      if (i == 0 || tbl[i].cset != tbl[i-1].cset) begin
        do_reset();
        load_set(tbl[i].cset);
      end
      feed(tbl[i].x, y, cyc);
      check($sformatf("vec%0d y_out", i), y, tbl[i].y);
      check($sformatf("vec%0d latency", i), cyc, 9);
    end

    // Reset held mid-MAC discards the sample
    x_in    = 23'(16384);
    x_valid = 1'b1;
    @(posedge clk);
    #1 x_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst busy", int'(busy), 0);
    check("midrst y_valid", int'(y_valid), 0);
    check("midrst y_out", int'(y_out), 0);
    check("midrst overrun", int'(overrun), 0);
    check("midrst mult_a", int'(mult_a), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (y_valid) seen++;
    end
    check("no y_valid after reset", seen, 0);
    @(posedge clk);
    #1;

    // Overrun: sample offered during MAC is dropped
    do_reset();
    wcoef(0, 16384);
    wcoef(1, 8192);
    feed(100, y, cyc);
    check("ovr first y", y, 100);
    x_in    = 23'(200);
    x_valid = 1'b1;
    @(posedge clk);
    #1 x_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 x_in = 23'(5000);
    x_valid = 1'b1;
    @(negedge clk);
    check("ovr pulse", int'(overrun), 1);
    check("ovr busy", int'(busy), 1);
    @(posedge clk);
    #1 x_valid = 1'b0;
    @(negedge clk);
    check("ovr cleared", int'(overrun), 0);
    wait_y(y, cyc);
    check("ovr current y", y, 250);
    feed(0, y, cyc);
    check("ovr next y", y, 100);

    // Coefficient write to the tap being read
    do_reset();
    wcoef(0, 16384);
    wcoef(1, 8192);
    x_in    = 23'(400);
    x_valid = 1'b1;
    @(posedge clk);
    #1 x_valid = 1'b0;
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 23'(8192);
    @(negedge clk);
    check("cw mult_a old", int'(mult_a), 16384);
    @(posedge clk);
    #1 coef_we = 1'b0;
    wait_y(y, cyc);
    check("cw current y", y, 400);
    feed(800, y, cyc);
    check("cw next y", y, 600);

    // Out-of-range coefficient addresses on the five-tap instance
    s_coef_we   = 1'b1;
    s_coef_addr = 3'd0;
    s_coef_data = 23'(16384);
    @(posedge clk);
    #1;
    for (int a = 5; a < 8; a++) begin
      s_coef_addr = 3'(a);
      s_coef_data = 23'(-8192);
      @(posedge clk);
      #1;
    end
    s_coef_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      s_x_in    = (k == 0) ? 23'(16384) : '0;
      s_x_valid = 1'b1;
      @(posedge clk);
      #1 s_x_valid = 1'b0;
      got = 0;
      sy  = 0;
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk);
        if (s_y_valid) begin
          got = c;
          sy  = int'($signed(s_y_out));
          break;
        end
      end
      @(posedge clk);
      #1;
      check($sformatf("small y%0d", k), sy, (k == 0) ? 16384 : 0);
      check($sformatf("small latency%0d", k), got, 6);
    end
    check("small idle busy", int'(s_busy), 0);
    check("small idle overrun", int'(s_overrun), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
